// File: rtl/l2_cache_pkg.sv
// Shared types and helpers for the L2 way-select path: FSM states, tree-PLRU
// victim walk and path update, and a lowest-set-bit priority encoder.
package l2_cache_pkg;

    localparam int MAX_WAYS = 64;
    localparam int WB_MAX   = 6;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESOLVE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    // The walk treats way w as the virtual node w + (ways - 1) hanging under the last tree level.
    function automatic logic [WB_MAX-1:0] plru_victim(input logic [MAX_WAYS-2:0] bits,
                                                      input int levels);
        int node;
        node = 0;
        for (int i = 0; i < WB_MAX; i++) begin
            if (i < levels) begin
                node = bits[WB_MAX'(node)] ? (2 * node + 2) : (2 * node + 1);
            end
        end
        return WB_MAX'(node - ((1 << levels) - 1));
    endfunction

    function automatic logic [MAX_WAYS-2:0] plru_update(input logic [MAX_WAYS-2:0] bits,
                                                        input logic [WB_MAX-1:0] way,
                                                        input int levels);
        logic [MAX_WAYS-2:0] res;
        int node;
        int parent;
        res  = bits;
        node = int'(way) + (1 << levels) - 1;
        for (int i = 0; i < WB_MAX; i++) begin
            if (i < levels) begin
                parent = (node - 1) / 2;
                // A left child has an odd index; point the parent right (1) to move away from it.
                res[WB_MAX'(parent)] = node[0];
                node = parent;
            end
        end
        return res;
    endfunction

    function automatic logic [WB_MAX-1:0] lowest_set(input logic [MAX_WAYS-1:0] vec);
        logic [WB_MAX-1:0] idx;
        idx = '0;
        for (int i = MAX_WAYS - 1; i >= 0; i--) begin
            if (vec[i]) idx = WB_MAX'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/way_select_controller_mux.sv
// Way multiplexor: picks one LINE_SIZE slice out of the flattened per-way line bus.
module way_select_controller_mux #(
    parameter int LINE_SIZE = 512,
    parameter int WAYS      = 8
) (
    input  logic [$clog2(WAYS)-1:0]     select,
    input  logic [WAYS*LINE_SIZE-1:0]   lines,
    output logic [LINE_SIZE-1:0]        line
);

    assign line = lines[select*LINE_SIZE +: LINE_SIZE];

endmodule

// File: rtl/way_select_controller.sv
// L2 way-select controller: accepts one lookup, resolves hit / invalid / PLRU way,
// registers the chosen line and status, and owns the per-set tree-PLRU state.
module way_select_controller
    import l2_cache_pkg::*;
#(
    parameter int LINE_SIZE = 512,
    parameter int WAYS      = 8,
    parameter int SETS      = 64
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        req_valid,
    output logic                        req_ready,
    input  logic [$clog2(SETS)-1:0]     req_index,
    input  logic [WAYS-1:0]             array_hit_vec,
    input  logic [WAYS-1:0]             array_valid_vec,
    input  logic [WAYS*LINE_SIZE-1:0]   array_lines,
    output logic [$clog2(WAYS)-1:0]     mux_select,
    output logic                        rsp_valid,
    input  logic                        rsp_ready,
    output logic                        rsp_hit,
    output logic                        rsp_error,
    output logic [$clog2(WAYS)-1:0]     rsp_way,
    output logic [LINE_SIZE-1:0]        rsp_line
);

    localparam int IW = $clog2(SETS);
    localparam int WW = $clog2(WAYS);
    localparam int NB = WAYS - 1;

    state_t            state;
    logic [IW-1:0]     idx_q;
    logic [NB-1:0]     plru [SETS];

    logic              any_hit;
    logic              multi_hit;
    logic              any_invalid;
    logic [WW-1:0]     res_way;
    logic [WW-1:0]     mux_sel;
    logic [LINE_SIZE-1:0] mux_line;

    always_comb begin
        any_hit     = |array_hit_vec;
        multi_hit   = |(array_hit_vec & (array_hit_vec - WAYS'(1)));
        any_invalid = ~(&array_valid_vec);
        res_way     = '0;
        if (any_hit) begin
            res_way = WW'(lowest_set(MAX_WAYS'(array_hit_vec)));
        end else if (any_invalid) begin
            res_way = WW'(lowest_set(MAX_WAYS'(~array_valid_vec)));
        end else begin
            res_way = WW'(plru_victim((MAX_WAYS-1)'(plru[idx_q]), WW));
        end
    end

    // The mux is steered by the way being resolved so its line is captured alongside mux_select.
    assign mux_sel = (state == RESOLVE) ? res_way : mux_select;

    way_select_controller_mux #(
        .LINE_SIZE (LINE_SIZE),
        .WAYS      (WAYS)
    ) u_way_mux (
        .select (mux_sel),
        .lines  (array_lines),
        .line   (mux_line)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx_q      <= '0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_hit    <= 1'b0;
            rsp_error  <= 1'b0;
            rsp_way    <= '0;
            rsp_line   <= '0;
            mux_select <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        idx_q     <= req_index;
                        req_ready <= 1'b0;
                        state     <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    rsp_way    <= res_way;
                    mux_select <= res_way;
                    rsp_hit    <= any_hit & ~multi_hit;
                    rsp_error  <= multi_hit;
                    rsp_line   <= mux_line;
                    rsp_valid  <= 1'b1;
                    state      <= RESPOND;
                end
                RESPOND: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    // Multi-hit is an error indication only; it must not disturb replacement history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) plru[s] <= '0;
        end else if (state == RESOLVE && !multi_hit) begin
            plru[idx_q] <= NB'(plru_update((MAX_WAYS-1)'(plru[idx_q]), WB_MAX'(res_way), WW));
        end
    end

endmodule

// File: tb/tb_way_select_controller.sv
// Directed scoreboard bench for way_select_controller: stimulus pushes expected
// responses, a monitor pops and compares on each response handshake.
module tb_way_select_controller;

    localparam int LS = 512;
    localparam int NW = 8;
    localparam int NS = 64;

    typedef struct {
        logic [2:0]    way;
        logic          hit;
        logic          err;
        logic [LS-1:0] line;
    } exp_t;

    logic               clk;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [5:0]         req_index;
    logic [NW-1:0]      array_hit_vec;
    logic [NW-1:0]      array_valid_vec;
    logic [NW*LS-1:0]   array_lines;
    logic [2:0]         mux_select;
    logic               rsp_valid;
    logic               rsp_ready;
    logic               rsp_hit;
    logic               rsp_error;
    logic [2:0]         rsp_way;
    logic [LS-1:0]      rsp_line;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    way_select_controller #(.LINE_SIZE(LS), .WAYS(NW), .SETS(NS)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_index       (req_index),
        .array_hit_vec   (array_hit_vec),
        .array_valid_vec (array_valid_vec),
        .array_lines     (array_lines),
        .mux_select      (mux_select),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_hit         (rsp_hit),
        .rsp_error       (rsp_error),
        .rsp_way         (rsp_way),
        .rsp_line        (rsp_line)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NW*LS-1:0] make_lines(input int seed);
        logic [NW*LS-1:0] v;
        for (int w = 0; w < NW; w++)
            for (int k = 0; k < LS / 32; k++)
                v[w*LS + k*32 +: 32] = 32'(seed) ^ 32'(w << 8) ^ 32'(k << 20);
        return v;
    endfunction

    function automatic logic [LS-1:0] line_of(input int seed, input int way);
        logic [NW*LS-1:0] v;
        v = make_lines(seed);
        return v[way*LS +: LS];
    endfunction

    task automatic chk(input string name, input logic [LS-1:0] got, input logic [LS-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_rsp", 1'b1, 1'b0);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_way", LS'(rsp_way), LS'(e.way));
                    chk("mux_select", LS'(mux_select), LS'(e.way));
                    chk("rsp_hit", LS'(rsp_hit), LS'(e.hit));
                    chk("rsp_error", LS'(rsp_error), LS'(e.err));
                    chk("rsp_line", rsp_line, e.line);
                end
            end
        end
    end

    task automatic issue(input logic [5:0] idx, input logic [7:0] hit, input logic [7:0] vld,
                         input int seed, input int way, input logic h, input logic er,
                         input int hold);
        exp_t e;
        @(negedge clk);
        chk("req_ready_idle", LS'(req_ready), LS'(1));
        req_valid = 1'b1;
        req_index = idx;
        rsp_ready = (hold == 0);
        e.way  = 3'(way);
        e.hit  = h;
        e.err  = er;
        e.line = line_of(seed, way);
        sb.push_back(e);
        @(posedge clk);
        #1;
        req_valid       = 1'b0;
        array_hit_vec   = hit;
        array_valid_vec = vld;
        array_lines     = make_lines(seed);
        @(negedge clk);
        chk("rsp_valid_early", LS'(rsp_valid), LS'(0));
        @(posedge clk);
        #1;
        array_lines   = make_lines(seed + 1000);
        array_hit_vec = ~hit;
        @(negedge clk);
        chk("rsp_valid_latency", LS'(rsp_valid), LS'(1));
        if (hold > 0) begin
            for (int c = 0; c < hold; c++) begin
                chk("hold_valid", LS'(rsp_valid), LS'(1));
                chk("hold_req_ready", LS'(req_ready), LS'(0));
                chk("hold_way", LS'(rsp_way), LS'(way));
                chk("hold_mux", LS'(mux_select), LS'(way));
                chk("hold_line", rsp_line, e.line);
                @(posedge clk);
                #1;
                array_lines = make_lines(int'($urandom));
                @(negedge clk);
            end
            @(posedge clk);
            #1;
            rsp_ready = 1'b1;
            @(negedge clk);
        end
        @(posedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n           = 1'b0;
        req_valid       = 1'b0;
        req_index       = '0;
        rsp_ready       = 1'b1;
        array_hit_vec   = '0;
        array_valid_vec = '0;
        array_lines     = '0;
        #23;
        chk("rst_req_ready", LS'(req_ready), LS'(1));
        chk("rst_rsp_valid", LS'(rsp_valid), LS'(0));
        chk("rst_mux", LS'(mux_select), LS'(0));
        chk("rst_line", rsp_line, '0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(6'd5, 8'h00, 8'hFF, 11, 0, 1'b0, 1'b0, 0);
        issue(6'd5, 8'h00, 8'hFF, 12, 4, 1'b0, 1'b0, 0);
        issue(6'd5, 8'h00, 8'hFF, 13, 2, 1'b0, 1'b0, 0);
        issue(6'd9, 8'b0010_0000, 8'hFF, 14, 5, 1'b1, 1'b0, 0);
        issue(6'd3, 8'h00, 8'b1111_0111, 15, 3, 1'b0, 1'b0, 0);
        issue(6'd12, 8'b0000_1010, 8'hFF, 16, 1, 1'b0, 1'b1, 0);
        issue(6'd12, 8'h00, 8'hFF, 17, 0, 1'b0, 1'b0, 0);
        issue(6'd20, 8'b0100_0000, 8'hFF, 18, 6, 1'b1, 1'b0, 5);
        issue(6'd21, 8'h00, 8'h00, 19, 0, 1'b0, 1'b0, 0);

        // Reset while a response is pending: it must be dropped.
        @(negedge clk);
        req_valid = 1'b1;
        req_index = 6'd5;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid       = 1'b0;
        array_hit_vec   = 8'h00;
        array_valid_vec = 8'hFF;
        array_lines     = make_lines(20);
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_valid", LS'(rsp_valid), LS'(1));
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", LS'(rsp_valid), LS'(0));
        chk("mid_rst_req_ready", LS'(req_ready), LS'(1));
        chk("mid_rst_way", LS'(rsp_way), LS'(0));
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;

        issue(6'd5, 8'h00, 8'hFF, 21, 0, 1'b0, 1'b0, 0);
        issue(6'd9, 8'h00, 8'hFF, 22, 0, 1'b0, 1'b0, 0);

        repeat (3) @(negedge clk);
        chk("sb_drained", LS'(sb.size()), LS'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
